// File: rtl/cacheline_arbiter_pkg.sv
// cache_arb_pkg: shared types for the cacheline arbiter.
//   arb_state_t : arbiter FSM states
//   mem_op_t    : operation captured for the adaptor on a grant
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RECOVER
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE
  } mem_op_t;

endpackage

// File: rtl/cacheline_arbiter_if.sv
// cacheline_arbiter_if: bundles the I-cache, D-cache and adaptor-side
// handshake/bus signals of the cacheline arbiter.
//   slave  : arbiter view (takes requests and mem_resp/mem_rdata,
//            drives responses and the adaptor command)
//   master : environment view (caches + adaptor)
interface cacheline_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one cacheline adaptor between the I-cache
// (read-only) and the D-cache (read/write). D has priority; I is forced
// through once D has won MAX_CONSEC times in a row while I was waiting.
// One whole-line transaction at a time, one RECOVER cycle between them.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : cacheline_arbiter_if.slave (cache requests/responses, adaptor)
//   busy  : high whenever the FSM is not IDLE
module cacheline_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                reset,
  cacheline_arbiter_if.slave  bus,
  output logic                busy
);

  localparam logic [3:0] MaxCnt = 4'(MAX_CONSEC);

  arb_state_t        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_op_t           op_q, op_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic req_i, req_d, grant_i, grant_d;
  logic resp_i, resp_d;

  // State and capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      op_q     <= OP_NONE;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
    end
  end

  // Arbitration and next-state / capture logic
  always_comb begin
    req_i   = bus.i_read;
    req_d   = bus.d_read | bus.d_write;
    grant_i = (state_q == IDLE) && req_i && (!req_d || (starve_q == MaxCnt));
    grant_d = (state_q == IDLE) && req_d && !grant_i;

    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    op_d     = op_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = GRANT_I;
          addr_d   = bus.i_addr;
          op_d     = OP_READ;
          wdata_d  = '0;
          starve_d = '0;
        end else if (grant_d) begin
          state_d = GRANT_D;
          addr_d  = bus.d_addr;
          // read+write together is treated as a writeback
          op_d    = bus.d_write ? OP_WRITE : OP_READ;
          wdata_d = bus.d_wdata;
          if (!req_i)                 starve_d = '0;
          else if (starve_q < MaxCnt) starve_d = starve_q + 4'd1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_resp) begin
          state_d = RECOVER;
          addr_d  = '0;
          op_d    = OP_NONE;
          wdata_d = '0;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: adaptor command from the capture registers, responses routed
  // combinationally so x_resp coincides with mem_resp.
  always_comb begin
    resp_i = bus.mem_resp && (state_q == GRANT_I);
    resp_d = bus.mem_resp && (state_q == GRANT_D);

    bus.mem_addr  = addr_q;
    bus.mem_read  = (op_q == OP_READ);
    bus.mem_write = (op_q == OP_WRITE);
    bus.mem_wdata = wdata_q;

    bus.i_resp  = resp_i;
    bus.i_rdata = resp_i ? bus.mem_rdata : '0;
    bus.d_resp  = resp_d;
    bus.d_rdata = resp_d ? bus.mem_rdata : '0;

    busy = (state_q != IDLE);
  end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

- Shares the single cacheline adaptor (256-bit LLC-side port) between the instruction cache (read-only) and the data cache (read/write).
- Sits between both cache controllers and the adaptor.
- Arbitrates with data-cache priority and a starvation cap for the instruction cache.
- Sequences one whole-line transaction at a time, with a one-cycle turnaround between transactions.

## Interface
Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, address width
- MAX_CONSEC, 4, consecutive D grants allowed while I waits (range 1–15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_addr  in  ADDR_W  I-cache line address
- i_read  in  1  I-cache read request, held until i_resp
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  I-cache completion pulse
- d_addr  in  ADDR_W  D-cache line address
- d_read  in  1  D-cache read request, held until d_resp
- d_write  in  1  D-cache writeback request, held until d_resp
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  D-cache completion pulse
- mem_addr  out  ADDR_W  to adaptor address_i
- mem_read  out  1  to adaptor read_i
- mem_write  out  1  to adaptor write_i
- mem_wdata  out  LINE_W  to adaptor line_i
- mem_rdata  in  LINE_W  from adaptor line_o
- mem_resp  in  1  from adaptor resp_o
- busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, GRANT_I, GRANT_D, RECOVER.
- Request signals: req_i = i_read; req_d = d_read | d_write.
- IDLE, arbitration:
  - I is granted if req_i and (!req_d or starve_cnt == MAX_CONSEC).
  - Otherwise D is granted if req_d.
  - Otherwise stay in IDLE.
- Capture on grant: in the grant cycle, latch address, op and wdata into registers (mem_addr, mem_read/mem_write, mem_wdata).
- d_read and d_write both high is illegal. The arbiter treats it as a write.
- GRANT_x:
  - Hold mem_* from the captured registers.
  - On mem_resp, go to RECOVER and clear mem_read, mem_write, mem_addr and mem_wdata.
- Response path, combinational:
  - x_resp = mem_resp & (state == GRANT_x).
  - x_rdata = mem_rdata while x_resp is high, else 0.
- RECOVER lasts one cycle with mem_read/mem_write low, then goes to IDLE. The requester drops its request during this cycle.
- starve_cnt (4-bit), updated only at an IDLE grant decision:
  - D granted while req_i is high: increment, saturating at MAX_CONSEC.
  - I granted, or req_i low: clear to 0.
- mem_resp outside GRANT_x is ignored (no x_resp).
- Requester deasserting mid-grant is a protocol violation. The arbiter completes the captured transaction and still pulses x_resp.

## Timing
- Reset values: state=IDLE, starve_cnt=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_resp=d_resp=0, i_rdata=d_rdata=0, busy=0.
- Reset mid-transaction aborts immediately. The adaptor shares the same reset.
- Request sampled in IDLE at cycle t: GRANT_x and mem_read/mem_write high at t+1.
- mem_resp at cycle c: x_resp at c, RECOVER at c+1, IDLE at c+2. Earliest next grant at c+3.
- Overhead per transaction: 3 cycles plus adaptor latency.
- Simultaneous requests in IDLE: resolved in the same cycle by the priority rule. The loser waits; its request stays asserted.

## Structure
- Shared package cache_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, GRANT_I, GRANT_D, RECOVER}
  - typedef enum mem_op_t {OP_NONE, OP_READ, OP_WRITE}
- Single module; no sub-module. The starvation counter and capture registers are inline.

## Test plan
- I alone: i_read=1, i_addr=0x0000_1000, mem_resp after 6 cycles with mem_rdata=0xA5…A5.
  - Expect mem_read at t+1 and mem_addr=0x1000.
  - Expect i_resp for 1 cycle with i_rdata=0xA5…A5, then busy low at c+2.
- D writeback: d_write=1, d_addr=0x2000, d_wdata=0x1234….
  - Expect mem_write=1, mem_wdata=0x1234… held until mem_resp.
  - Expect d_resp 1 cycle, mem_write low in RECOVER.
- Contention: i_read and d_read both held continuously, MAX_CONSEC=4.
  - Expect grant order D,D,D,D,I,D,D,D,D,I.
  - Expect starve_cnt=4 before each I grant.
- Illegal d_read & d_write: expect mem_write=1, mem_read=0.
- Reset asserted mid-GRANT_D, 3 cycles after grant: expect all outputs 0 asynchronously and state IDLE. After release, a pending i_read is granted next.
- Stray mem_resp in IDLE: expect no i_resp/d_resp and state unchanged.
